// File: rtl/gan_batch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | gan_batch_sequencer: noise stream -> start/done GAN core -> result FIFO  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module gan_batch_sequencer #(
  parameter int DATA_W      = 16,
  parameter int NOISE_N     = 2,
  parameter int PIX_N       = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NOISE_N*DATA_W-1:0] in_noise,
  output logic                      core_start,
  output logic [NOISE_N*DATA_W-1:0] core_noise,
  input  logic                      core_done,
  input  logic [PIX_N*DATA_W-1:0]   core_pixels,
  input  logic [DATA_W-1:0]         core_prob,
  input  logic [DATA_W-1:0]         thresh,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [PIX_N*DATA_W-1:0]   res_pixels,
  output logic [DATA_W-1:0]         res_prob,
  output logic                      res_real,
  output logic [15:0]               res_tag,
  output logic [15:0]               job_cnt,
  output logic [15:0]               real_cnt,
  output logic                      busy,
  output logic                      err_timeout,
  input  logic                      clear_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

  state_t                      state_q, state_d;
  logic [WD_W-1:0]             wdog_q, wdog_d;
  logic [NOISE_N*DATA_W-1:0]   noise_q, noise_d;
  logic                        err_q, err_d;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q;
  logic [15:0]                 job_cnt_q, real_cnt_q;
  logic [PIX_N*DATA_W-1:0]     pix_mem_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]           prob_mem_q [FIFO_DEPTH];
  logic                        real_mem_q [FIFO_DEPTH];
  logic [15:0]                 tag_mem_q  [FIFO_DEPTH];

  logic push, pop, is_real, slot_free;

  assign slot_free = (count_q < CNT_W'(FIFO_DEPTH));
  assign is_real   = $signed(core_prob) > $signed(thresh);
  assign pop       = (count_q != '0) && res_ready;

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    noise_d    = noise_q;
    err_d      = err_q;
    push       = 1'b0;
    core_start = 1'b0;
    in_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          noise_d = in_noise;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        wdog_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        // A done on the final watchdog cycle still completes the job.
        if (core_done) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (clear_err) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wdog_q     <= '0;
      noise_q    <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      job_cnt_q  <= '0;
      real_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      noise_q <= noise_d;
      err_q   <= err_d;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
        job_cnt_q  <= job_cnt_q + 16'd1;
        real_cnt_q <= real_cnt_q + 16'(is_real);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once the count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pix_mem_q[wr_ptr_q]  <= core_pixels;
      prob_mem_q[wr_ptr_q] <= core_prob;
      real_mem_q[wr_ptr_q] <= is_real;
      tag_mem_q[wr_ptr_q]  <= job_cnt_q;
    end
  end

  assign core_noise  = noise_q;
  assign res_valid   = (count_q != '0);
  assign res_pixels  = pix_mem_q[rd_ptr_q];
  assign res_prob    = prob_mem_q[rd_ptr_q];
  assign res_real    = real_mem_q[rd_ptr_q];
  assign res_tag     = tag_mem_q[rd_ptr_q];
  assign job_cnt     = job_cnt_q;
  assign real_cnt    = real_cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule
`default_nettype wire
